// File: rtl/d_ext_alu_wb_ctrl.sv
// Issue/writeback controller for the D-extension ALU: launches one op, samples the ALU result
// after ALU_LAT cycles and queues it in a 2-entry writeback FIFO. Macro: D_EXT_ALU_NANBOX_EN.
module d_ext_alu_wb_ctrl #(
    parameter int ALU_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [63:0] req_rs3,
    input  logic [31:0] req_fs_rs1,
    input  logic [63:0] req_int_rs1,
    output logic [4:0]  alu_op,
    output logic [63:0] rs1,
    output logic [63:0] rs2,
    output logic [63:0] rs3,
    output logic [31:0] fs_rs1,
    output logic [63:0] int_rs1,
    input  logic [63:0] result,
    input  logic [31:0] fs_result,
    input  logic [63:0] int_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_dest,
    output logic [63:0] wb_data
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [4:0]  rd_p0;
    logic [1:0]  dest_p0;
    logic        accept, push, pop;
    logic [4:0]  buf_rd   [2];
    logic [1:0]  buf_dest [2];
    logic [63:0] buf_data [2];
    logic        head, wr_idx;
    logic [1:0]  count;

    function automatic logic [1:0] class_of(input logic [4:0] op);
        if (!op[4])
            return 2'd0;
        else if (!op[3])
            return 2'd2;
        else
            return 2'd1;
    endfunction

    function automatic logic [63:0] sel_data(input logic [1:0] dest, input logic [63:0] d_res,
                                             input logic [31:0] s_res, input logic [63:0] i_res);
        case (dest)
            2'd2:    return i_res;
`ifdef D_EXT_ALU_NANBOX_EN
            2'd1:    return {32'hFFFF_FFFF, s_res};
`else
            2'd1:    return {32'h0000_0000, s_res};
`endif
            default: return d_res;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = (count < 2'd2);
                if (req_valid && req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign push   = (state == WAIT) && (cnt == 4'd1);
    assign pop    = wb_valid && wb_ready;

    // Launch stage: operands and op class held until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_p0   <= 5'd0;
            dest_p0 <= 2'd0;
            alu_op  <= 5'd0;
            rs1     <= 64'd0;
            rs2     <= 64'd0;
            rs3     <= 64'd0;
            fs_rs1  <= 32'd0;
            int_rs1 <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= 4'(ALU_LAT);
                rd_p0   <= req_rd;
                dest_p0 <= class_of(req_op);
                alu_op  <= req_op;
                rs1     <= req_rs1;
                rs2     <= req_rs2;
                rs3     <= req_rs3;
                fs_rs1  <= req_fs_rs1;
                int_rs1 <= req_int_rs1;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Writeback stage: tail slot is the one after head when one entry is already queued
    assign wr_idx = head ^ count[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                buf_rd[k]   <= 5'd0;
                buf_dest[k] <= 2'd0;
                buf_data[k] <= 64'd0;
            end
        end else begin
            if (push) begin
                buf_rd[wr_idx]   <= rd_p0;
                buf_dest[wr_idx] <= dest_p0;
                buf_data[wr_idx] <= sel_data(dest_p0, result, fs_result, int_result);
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign wb_valid = (count != 2'd0);
    assign wb_rd    = buf_rd[head];
    assign wb_dest  = buf_dest[head];
    assign wb_data  = buf_data[head];

endmodule

// File: tb/tb_d_ext_alu_wb_ctrl.sv
// Bench for d_ext_alu_wb_ctrl: a fake ALU derives results from the launched operands and a
// queue-based model predicts handshakes, writeback contents and launched operands each cycle.
module tb_d_ext_alu_wb_ctrl;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [4:0]  req_rd = '0;
    logic [63:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0, req_int_rs1 = '0;
    logic [31:0] req_fs_rs1 = '0;
    logic [4:0]  alu_op;
    logic [63:0] rs1, rs2, rs3, int_rs1;
    logic [31:0] fs_rs1;
    logic [63:0] result, int_result;
    logic [31:0] fs_result;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_dest;
    logic [63:0] wb_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  dest;
        logic [63:0] data;
        int          rdy;
    } ent_t;
    ent_t q[$];

    logic [4:0]  m_op;
    logic [63:0] m_rs1, m_rs2, m_rs3, m_int;
    logic [31:0] m_fs;

    d_ext_alu_wb_ctrl #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .req_fs_rs1(req_fs_rs1), .req_int_rs1(req_int_rs1),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rs3(rs3), .fs_rs1(fs_rs1), .int_rs1(int_rs1),
        .result(result), .fs_result(fs_result), .int_result(int_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_dest(wb_dest),
        .wb_data(wb_data)
    );

    // Fake ALU: distinct functions of the launched operands
    assign result     = rs1 + rs2;
    assign int_result = int_rs1 ^ rs3;
    assign fs_result  = fs_rs1 ^ rs2[31:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t expect_entry(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [63:0] a, b, c, input logic [31:0] f,
                                          input logic [63:0] i);
        ent_t e;
        e.rd = rd;
        e.rdy = 0;
        if (op < 16) begin
            e.dest = 2'd0;
            e.data = a + b;
        end else if (op < 24) begin
            e.dest = 2'd2;
            e.data = i ^ c;
        end else begin
            e.dest = 2'd1;
`ifdef D_EXT_ALU_NANBOX_EN
            e.data = {32'hFFFF_FFFF, f ^ b[31:0]};
`else
            e.data = {32'h0000_0000, f ^ b[31:0]};
`endif
        end
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rs3 = '0; m_fs = '0; m_int = '0;
    endtask

    // One cycle: compare DUT against model, drive inputs, advance model, step to next negedge
    task automatic step(input bit rv, input logic [4:0] op, rd, input logic [63:0] a, b, c,
                        input logic [31:0] f, input logic [63:0] i, input bit wr,
                        output bit acc);
        int vis;
        bit infl;
        ent_t e;
        vis = 0;
        infl = 0;
        foreach (q[k]) begin
            if (q[k].rdy <= cyc) vis++;
            else infl = 1;
        end
        check("wb_valid", wb_valid, vis > 0);
        check("req_ready", req_ready, !infl && vis < 2);
        if (vis > 0) begin
            check("wb_rd", wb_rd, q[0].rd);
            check("wb_dest", wb_dest, q[0].dest);
            check("wb_data", wb_data, q[0].data);
        end
        check("alu_op", alu_op, m_op);
        check("rs1", rs1, m_rs1);
        check("rs2", rs2, m_rs2);
        check("rs3", rs3, m_rs3);
        check("fs_rs1", fs_rs1, m_fs);
        check("int_rs1", int_rs1, m_int);
        req_valid = rv; req_op = op; req_rd = rd;
        req_rs1 = a; req_rs2 = b; req_rs3 = c; req_fs_rs1 = f; req_int_rs1 = i;
        wb_ready = wr;
        acc = rv && !infl && vis < 2;
        if (wr && vis > 0) void'(q.pop_front());
        if (acc) begin
            e = expect_entry(op, rd, a, b, c, f, i);
            e.rdy = cyc + 1 + LAT;
            q.push_back(e);
            m_op = op; m_rs1 = a; m_rs2 = b; m_rs3 = c; m_fs = f; m_int = i;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] op, rd, input logic [63:0] a, b, c,
                         input logic [31:0] f, input logic [63:0] i, input bit wr);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 40) begin
            step(1'b1, op, rd, a, b, c, f, i, wr, acc);
            n++;
        end
    endtask

    task automatic idle(input int n, input bit wr);
        bit acc;
        for (int k = 0; k < n; k++)
            step(1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 32'd0, 64'd0, wr, acc);
    endtask

    initial begin
        bit acc;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_dest", wb_dest, 2'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_alu_op", alu_op, 5'd0);
        check("rst_rs1", rs1, 64'd0);
        check("rst_int_rs1", int_rs1, 64'd0);
        rst = 1'b0;

        // Reset in the middle of WAIT discards the in-flight op
        issue(5'd5, 5'd9, 64'h11, 64'h22, 64'h33, 32'h44, 64'h55, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_wb_valid", wb_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_alu_op", alu_op, 5'd0);
        check("midrst_rs1", rs1, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(LAT + 3, 1'b1);

        // Single FP64 op
        issue(5'd2, 5'd7, 64'h4000_0000_0000_0000, 64'd0, 64'h77, 32'h1, 64'h2, 1'b0);
        check("launch_rs1", rs1, 64'h4000_0000_0000_0000);
        check("launch_rs3", rs3, 64'h77);
        idle(LAT, 1'b0);
        check("single_valid", wb_valid, 1'b1);
        check("single_rd", wb_rd, 5'd7);
        check("single_dest", wb_dest, 2'd0);
        check("single_data", wb_data, 64'h4000_0000_0000_0000);
        idle(1, 1'b1);
        check("single_popped", wb_valid, 1'b0);

        // Class select: integer and single-precision
        issue(5'd18, 5'd3, 64'd0, 64'd0, 64'd0, 32'd0, 64'h1, 1'b0);
        idle(LAT, 1'b0);
        check("int_dest", wb_dest, 2'd2);
        check("int_data", wb_data, 64'h1);
        idle(1, 1'b1);
        issue(5'd26, 5'd4, 64'd0, 64'd0, 64'd0, 32'h3F80_0000, 64'd0, 1'b0);
        idle(LAT, 1'b0);
        check("fs_dest", wb_dest, 2'd1);
`ifdef D_EXT_ALU_NANBOX_EN
        check("fs_data", wb_data, 64'hFFFF_FFFF_3F80_0000);
`else
        check("fs_data", wb_data, 64'h0000_0000_3F80_0000);
`endif
        idle(1, 1'b1);

        // Backpressure: two buffered, third held until the consumer drains
        issue(5'd1, 5'd10, 64'h100, 64'h1, 64'd0, 32'd0, 64'd0, 1'b0);
        issue(5'd20, 5'd11, 64'd0, 64'd0, 64'hF0, 32'd0, 64'h0F, 1'b0);
        for (int k = 0; k < 8; k++)
            step(1'b1, 5'd30, 5'd12, 64'd0, 64'h5, 64'd0, 32'hA0, 64'd0, 1'b0, acc);
        check("bp_ready", req_ready, 1'b0);
        check("bp_head_rd", wb_rd, 5'd10);
        issue(5'd30, 5'd12, 64'd0, 64'h5, 64'd0, 32'hA0, 64'd0, 1'b1);
        idle(LAT + 4, 1'b1);

        // Push and pop on the same edge with one entry queued
        issue(5'd3, 5'd20, 64'h1000, 64'h1, 64'd0, 32'd0, 64'd0, 1'b0);
        idle(LAT, 1'b0);
        issue(5'd4, 5'd21, 64'h2000, 64'h2, 64'd0, 32'd0, 64'd0, 1'b0);
        idle(LAT - 1, 1'b0);
        idle(1, 1'b1);
        check("pp_valid", wb_valid, 1'b1);
        check("pp_rd", wb_rd, 5'd21);
        check("pp_data", wb_data, 64'h2002);
        idle(2, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 32'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0, acc);
        idle(LAT + 6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
